// File: rtl/retire_stage.sv
// retire_stage: commits up to three reorder-buffer entries per cycle.
// Lane 2 is the oldest, lane 0 the youngest. The oldest mispredict or halt
// in a group ends it, and the younger lanes after it are discarded.
// The stage updates the architectural map and the free list, sends
// predictor updates, counts retired instructions, and generates the
// recovery pulse and the halt state.
module retire_stage #(
    parameter int PRW   = 6,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0]                ret_valid,
    input  logic [2:0][4:0]           ret_dest_areg,
    input  logic [2:0][PRW-1:0]       ret_Tnew,
    input  logic [2:0][PRW-1:0]       ret_Told,
    input  logic [2:0][XLEN-1:0]      ret_pc,
    input  logic [2:0]                ret_is_branch,
    input  logic [2:0]                ret_taken,
    input  logic [2:0]                ret_precise_need,
    input  logic [2:0][XLEN-1:0]      ret_target_pc,
    input  logic [2:0]                ret_halt,
    output logic [31:0][PRW-1:0]      arch_map,
    output logic [2:0]                free_valid,
    output logic [2:0][PRW-1:0]       free_preg,
    output logic                      recover_en,
    output logic [XLEN-1:0]           recover_pc,
    output logic [2:0]                bp_update_en,
    output logic [2:0][XLEN-1:0]      bp_update_pc,
    output logic [2:0]                bp_update_taken,
    output logic [2:0][XLEN-1:0]      bp_update_target,
    output logic [CNT_W-1:0]          retired_count,
    output logic                      halted
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_RECOVER,
        ST_HALTED
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [2:0]             eff;        // lanes that actually commit this cycle
    logic [1:0]             eff_cnt;
    logic                   stop;
    logic                   term_halt;
    logic                   term_flush;
    logic [XLEN-1:0]        flush_pc;
    logic [31:0][PRW-1:0]   arch_map_nxt;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state always uses non-blocking assignments, so every flop samples pre-edge values.
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next-state logic: a mispredict gives one RECOVER cycle, and a halt is terminal.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (term_halt)       state_nxt = ST_HALTED;
                else if (term_flush) state_nxt = ST_RECOVER;
            end
            ST_RECOVER: state_nxt = ST_RUN;
            ST_HALTED:  state_nxt = ST_HALTED;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: the recovery pulse and the halt flag come straight from the state register.
    always_comb begin
        recover_en = (state == ST_RECOVER);
        halted     = (state == ST_HALTED);
    end

    // Scan the lanes from oldest to youngest. The first halt or mispredict ends the group.
    always_comb begin
        // NOTE: every comb output gets a default before any conditional logic, so no latch is inferred.
        eff        = '0;
        eff_cnt    = '0;
        stop       = 1'b0;
        term_halt  = 1'b0;
        term_flush = 1'b0;
        flush_pc   = '0;
        if (state == ST_RUN) begin
            for (int i = 2; i >= 0; i--) begin
                if (ret_valid[i] && !stop) begin
                    eff[i]  = 1'b1;
                    eff_cnt = eff_cnt + 2'd1;
                    if (ret_halt[i]) begin
                        stop      = 1'b1;
                        term_halt = 1'b1;
                    end else if (ret_precise_need[i]) begin
                        stop       = 1'b1;
                        term_flush = 1'b1;
                        flush_pc   = ret_target_pc[i];
                    end
                end
            end
        end
    end

    // Next map contents. Lanes are applied oldest first, so the youngest write to an areg wins.
    always_comb begin
        arch_map_nxt = arch_map;
        for (int i = 2; i >= 0; i--) begin
            if (eff[i] && (ret_dest_areg[i] != 5'd0))
                arch_map_nxt[ret_dest_areg[i]] = ret_Tnew[i];
        end
    end

    // Registered datapath outputs: map, free list, predictor updates, redirect PC, and counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the map is a visible register array with a defined reset image, so every entry is reset to the identity mapping.
            for (int i = 0; i < 32; i++) arch_map[i] <= PRW'(i);
            free_valid       <= '0;
            free_preg        <= '0;
            bp_update_en     <= '0;
            bp_update_pc     <= '0;
            bp_update_taken  <= '0;
            bp_update_target <= '0;
            recover_pc       <= '0;
            retired_count    <= '0;
        end else begin
            arch_map      <= arch_map_nxt;
            retired_count <= retired_count + CNT_W'(eff_cnt);
            if (term_flush) recover_pc <= flush_pc;
            for (int i = 0; i < 3; i++) begin
                free_valid[i]   <= eff[i] && (ret_dest_areg[i] != 5'd0);
                bp_update_en[i] <= eff[i] && ret_is_branch[i];
                if (eff[i] && (ret_dest_areg[i] != 5'd0))
                    free_preg[i] <= ret_Told[i];
                if (eff[i] && ret_is_branch[i]) begin
                    bp_update_pc[i]     <= ret_pc[i];
                    bp_update_taken[i]  <= ret_taken[i];
                    bp_update_target[i] <= ret_precise_need[i] ? ret_target_pc[i]
                                                               : ret_pc[i] + XLEN'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Testbench for retire_stage. It runs directed vectors, hand-written
// sequences for recovery, halt and reset, and randomized groups. All
// results are compared against an instruction-level reference model.
module tb_retire_stage;

    localparam int PRW = 6;
    localparam int XLEN = 32;
    localparam int CNT_W = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [2:0]           ret_valid;
    logic [2:0][4:0]      ret_dest_areg;
    logic [2:0][PRW-1:0]  ret_Tnew, ret_Told;
    logic [2:0][XLEN-1:0] ret_pc, ret_target_pc;
    logic [2:0]           ret_is_branch, ret_taken, ret_precise_need, ret_halt;
    logic [31:0][PRW-1:0] arch_map;
    logic [2:0]           free_valid;
    logic [2:0][PRW-1:0]  free_preg;
    logic                 recover_en;
    logic [XLEN-1:0]      recover_pc;
    logic [2:0]           bp_update_en;
    logic [2:0][XLEN-1:0] bp_update_pc, bp_update_target;
    logic [2:0]           bp_update_taken;
    logic [CNT_W-1:0]     retired_count;
    logic                 halted;

    retire_stage #(.PRW(PRW), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_dest_areg(ret_dest_areg),
        .ret_Tnew(ret_Tnew), .ret_Told(ret_Told), .ret_pc(ret_pc),
        .ret_is_branch(ret_is_branch), .ret_taken(ret_taken),
        .ret_precise_need(ret_precise_need), .ret_target_pc(ret_target_pc),
        .ret_halt(ret_halt), .arch_map(arch_map),
        .free_valid(free_valid), .free_preg(free_preg),
        .recover_en(recover_en), .recover_pc(recover_pc),
        .bp_update_en(bp_update_en), .bp_update_pc(bp_update_pc),
        .bp_update_taken(bp_update_taken), .bp_update_target(bp_update_target),
        .retired_count(retired_count), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]           valid;
        logic [2:0][4:0]      dest;
        logic [2:0][PRW-1:0]  tnew;
        logic [2:0][PRW-1:0]  told;
        logic [2:0][XLEN-1:0] pc;
        logic [2:0]           br;
        logic [2:0]           taken;
        logic [2:0]           pn;
        logic [2:0][XLEN-1:0] tgt;
        logic [2:0]           halt;
    } grp_t;

    typedef struct {
        grp_t       g;
        logic [2:0] exp_free;
        int         exp_cnt;
        logic [4:0] chk_areg;
        logic [5:0] chk_val;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [PRW-1:0]       m_map [32];
    int                   m_state;   // 0 run, 1 recovering, 2 halted
    logic [CNT_W-1:0]     m_count;
    logic [2:0]           e_free, e_bp, e_bp_tk;
    logic [2:0][PRW-1:0]  e_preg;
    logic [2:0][XLEN-1:0] e_bp_pc, e_bp_tg;
    logic [XLEN-1:0]      e_rpc;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic grp_t empty_grp();
        grp_t g;
        g.valid = '0; g.dest = '0; g.tnew = '0; g.told = '0; g.pc = '0;
        g.br = '0; g.taken = '0; g.pn = '0; g.tgt = '0; g.halt = '0;
        return g;
    endfunction

    function automatic grp_t add_lane(input grp_t gi, input int l, input logic [4:0] d,
                                      input logic [5:0] n, input logic [5:0] o);
        grp_t g = gi;
        g.valid[l] = 1'b1; g.dest[l] = d; g.tnew[l] = n; g.told[l] = o;
        g.pc[l] = 32'h1000 + 32'(l * 4);
        return g;
    endfunction

    function automatic logic [191:0] identity_map();
        logic [31:0][PRW-1:0] m;
        for (int i = 0; i < 32; i++) m[i] = PRW'(i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = PRW'(i);
        m_state = 0; m_count = '0;
        e_free = '0; e_bp = '0; e_bp_tk = '0; e_preg = '0;
        e_bp_pc = '0; e_bp_tg = '0; e_rpc = '0;
    endtask

    // Retire instructions in program order (oldest lane first). A halt or a
    // mispredict ends the group.
    task automatic model_step(input grp_t g, input logic rst);
        bit stop = 0;
        int nxt = 0;
        if (rst) begin
            model_reset();
            return;
        end
        e_free = '0;
        e_bp   = '0;
        if (m_state == 0) begin
            for (int l = 2; l >= 0; l--) begin
                if (g.valid[l] && !stop) begin
                    if (g.dest[l] != 0) begin
                        m_map[g.dest[l]] = g.tnew[l];
                        e_free[l] = 1'b1;
                        e_preg[l] = g.told[l];
                    end
                    if (g.br[l]) begin
                        e_bp[l]    = 1'b1;
                        e_bp_pc[l] = g.pc[l];
                        e_bp_tk[l] = g.taken[l];
                        e_bp_tg[l] = g.pn[l] ? g.tgt[l] : g.pc[l] + 32'd4;
                    end
                    m_count = m_count + 1;
                    if (g.halt[l]) begin
                        stop = 1; nxt = 2;
                    end else if (g.pn[l]) begin
                        stop = 1; nxt = 1; e_rpc = g.tgt[l];
                    end
                end
            end
            m_state = nxt;
        end else if (m_state == 1) begin
            m_state = 0;
        end
    endtask

    task automatic compare_all();
        logic [31:0][PRW-1:0] em;
        for (int i = 0; i < 32; i++) em[i] = m_map[i];
        check("recover_en", 192'(recover_en), 192'(m_state == 1));
        check("halted", 192'(halted), 192'(m_state == 2));
        check("retired_count", 192'(retired_count), 192'(m_count));
        check("free_valid", 192'(free_valid), 192'(e_free));
        check("bp_update_en", 192'(bp_update_en), 192'(e_bp));
        check("arch_map", 192'(arch_map), 192'(em));
        if (m_state == 1) check("recover_pc", 192'(recover_pc), 192'(e_rpc));
        for (int l = 0; l < 3; l++) begin
            if (e_free[l]) check($sformatf("free_preg[%0d]", l), 192'(free_preg[l]), 192'(e_preg[l]));
            if (e_bp[l]) begin
                check($sformatf("bp_pc[%0d]", l), 192'(bp_update_pc[l]), 192'(e_bp_pc[l]));
                check($sformatf("bp_taken[%0d]", l), 192'(bp_update_taken[l]), 192'(e_bp_tk[l]));
                check($sformatf("bp_target[%0d]", l), 192'(bp_update_target[l]), 192'(e_bp_tg[l]));
            end
        end
    endtask

    task automatic step(input grp_t g, input logic rst);
        reset            = rst;
        ret_valid        = g.valid;
        ret_dest_areg    = g.dest;
        ret_Tnew         = g.tnew;
        ret_Told         = g.told;
        ret_pc           = g.pc;
        ret_is_branch    = g.br;
        ret_taken        = g.taken;
        ret_precise_need = g.pn;
        ret_target_pc    = g.tgt;
        ret_halt         = g.halt;
        model_step(g, rst);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    function automatic grp_t rand_grp();
        grp_t g = empty_grp();
        for (int l = 0; l < 3; l++) begin
            g.valid[l] = ($urandom_range(0, 3) != 0);
            g.dest[l]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            g.tnew[l]  = 6'($urandom);
            g.told[l]  = 6'($urandom);
            g.pc[l]    = $urandom & ~32'h3;
            g.br[l]    = ($urandom_range(0, 2) == 0);
            g.taken[l] = 1'($urandom);
            g.pn[l]    = g.br[l] && ($urandom_range(0, 4) == 0);
            g.tgt[l]   = $urandom & ~32'h3;
            g.halt[l]  = ($urandom_range(0, 39) == 0);
        end
        return g;
    endfunction

    initial begin
        vec_t tbl[3];
        grp_t g;

        model_reset();
        reset = 1'b1;

        // Reset state.
        step(empty_grp(), 1'b1);
        check("reset arch_map identity", 192'(arch_map), identity_map());
        check("reset arch_map[5]", 192'(arch_map[5]), 192'(5));
        check("reset halted", 192'(halted), 192'(0));
        check("reset count", 192'(retired_count), 192'(0));

        // Directed single-cycle groups.
        tbl[0].g = add_lane(empty_grp(), 2, 5'd5, 6'd40, 6'd5);
        tbl[0].exp_free = 3'b100; tbl[0].exp_cnt = 1; tbl[0].chk_areg = 5'd5; tbl[0].chk_val = 6'd40;

        g = add_lane(empty_grp(), 2, 5'd7, 6'd33, 6'd10);
        g = add_lane(g, 1, 5'd7, 6'd34, 6'd11);
        tbl[1].g = add_lane(g, 0, 5'd7, 6'd35, 6'd12);
        tbl[1].exp_free = 3'b111; tbl[1].exp_cnt = 4; tbl[1].chk_areg = 5'd7; tbl[1].chk_val = 6'd35;

        g = add_lane(empty_grp(), 2, 5'd0, 6'd50, 6'd51);
        tbl[2].g = add_lane(g, 1, 5'd3, 6'd20, 6'd9);
        tbl[2].exp_free = 3'b010; tbl[2].exp_cnt = 6; tbl[2].chk_areg = 5'd0; tbl[2].chk_val = 6'd0;

        for (int i = 0; i < 3; i++) begin
            step(tbl[i].g, 1'b0);
            check($sformatf("tbl%0d free_valid", i), 192'(free_valid), 192'(tbl[i].exp_free));
            check($sformatf("tbl%0d count", i), 192'(retired_count), 192'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d map entry", i), 192'(arch_map[tbl[i].chk_areg]), 192'(tbl[i].chk_val));
        end
        check("tbl free_preg[1]", 192'(free_preg[1]), 192'(9));

        // A mispredict on lane 1 squashes lane 0.
        g = add_lane(empty_grp(), 2, 5'd0, 6'd0, 6'd0);
        g.br[2] = 1'b1; g.taken[2] = 1'b1; g.pc[2] = 32'h200;
        g = add_lane(g, 1, 5'd0, 6'd0, 6'd0);
        g.br[1] = 1'b1; g.pn[1] = 1'b1; g.pc[1] = 32'h204; g.tgt[1] = 32'h100; g.taken[1] = 1'b1;
        g = add_lane(g, 0, 5'd4, 6'd44, 6'd4);
        step(g, 1'b0);
        check("mp recover_en", 192'(recover_en), 192'(1));
        check("mp recover_pc", 192'(recover_pc), 192'(32'h100));
        check("mp bp_update_en", 192'(bp_update_en), 192'(3'b110));
        check("mp bp_target[2]", 192'(bp_update_target[2]), 192'(32'h204));
        check("mp squashed lane0 map", 192'(arch_map[4]), 192'(4));
        check("mp count", 192'(retired_count), 192'(8));
        // Inputs are ignored during the RECOVER cycle.
        step(add_lane(empty_grp(), 2, 5'd4, 6'd55, 6'd4), 1'b0);
        check("rc recover_en drop", 192'(recover_en), 192'(0));
        check("rc map ignored", 192'(arch_map[4]), 192'(4));
        check("rc count ignored", 192'(retired_count), 192'(8));

        // A halt on lane 2 that also has a mispredict: the halt wins.
        g = add_lane(empty_grp(), 2, 5'd0, 6'd0, 6'd0);
        g.halt[2] = 1'b1; g.br[2] = 1'b1; g.pn[2] = 1'b1; g.tgt[2] = 32'h500;
        g = add_lane(g, 1, 5'd9, 6'd60, 6'd9);
        step(g, 1'b0);
        check("halt halted", 192'(halted), 192'(1));
        check("halt no recover", 192'(recover_en), 192'(0));
        check("halt count", 192'(retired_count), 192'(9));
        check("halt squash lane1", 192'(arch_map[9]), 192'(9));
        for (int i = 0; i < 2; i++) begin
            step(add_lane(empty_grp(), 2, 5'd9, 6'd61, 6'd9), 1'b0);
            check("halted hold", 192'(halted), 192'(1));
            check("halted count hold", 192'(retired_count), 192'(9));
        end
        step(empty_grp(), 1'b1);
        check("halt reset halted", 192'(halted), 192'(0));
        check("halt reset map", 192'(arch_map), identity_map());

        // A reset asserted during the RECOVER cycle.
        g = add_lane(empty_grp(), 0, 5'd2, 6'd22, 6'd2);
        g.br[0] = 1'b1; g.pn[0] = 1'b1; g.tgt[0] = 32'h300;
        step(g, 1'b0);
        check("rr recover_en", 192'(recover_en), 192'(1));
        check("rr map write", 192'(arch_map[2]), 192'(22));
        step(add_lane(empty_grp(), 2, 5'd6, 6'd1, 6'd6), 1'b1);
        check("rr recover_en", 192'(recover_en), 192'(0));
        check("rr count", 192'(retired_count), 192'(0));
        check("rr map", 192'(arch_map), identity_map());
        check("rr free_valid", 192'(free_valid), 192'(0));

        // Randomized traffic checked against the model.
        for (int i = 0; i < 400; i++) begin
            logic rst;
            rst = ($urandom_range(0, 59) == 0) || (m_state == 2 && $urandom_range(0, 3) == 0);
            step(rand_grp(), rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
